io_bank: RTL and testbench
==========================

Name: io_bank

Overview:
- Parametrised memory-mapped I/O peripheral on the 8-bit CPU I/O bus; generalises the single-output, single-switch-port block.
- NUM_OUT writable output registers and NUM_IN input ports.
- Each input port gets a 2-flop synchroniser and a debouncer, sticky change flags (write-1-to-clear), per-port interrupt masks and a registered interrupt line.
- Sits on the I/O select/address/NOE/NWE strobes alongside other I/O devices; occupies a 64-address window at BASE_ADDR.

Parameters:
- NUM_OUT, 2, number of 8-bit output registers (1..16)
- NUM_IN, 2, number of 8-bit input ports (1..16)
- BASE_ADDR, 8'h00, window base; must be 64-aligned
- DEBOUNCE_CYCLES, 16, clocks of stability before a synchronised input is accepted (1..65535)

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_bus  in  8  write data from CPU bus
- o_bus  out  8  read data to CPU bus
- o_busNOE  out  1  active-low bus drive enable
- i_ioSelect  in  1  I/O space select
- i_ioAddress  in  8  I/O address
- i_ioNOE  in  1  active-low read strobe
- i_ioNWE  in  1  active-low write strobe
- o_output  out  8*NUM_OUT  output registers, port k at bits [8k+7:8k]
- i_switches  in  8*NUM_IN  asynchronous input pins, port k at bits [8k+7:8k]
- o_irq  out  1  registered interrupt request, active-high

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - i_reset high at an edge clears outputs, synchroniser flops, debounced values, counters, flags, masks and o_irq to 0.
  - i_reset dominates a simultaneous write.
- hit = i_ioSelect && i_ioAddress[7:6] == BASE_ADDR[7:6]; off = i_ioAddress[5:0].
- Address map, where k is the low nibble of off:
  - 0x00+k: OUT[k], R/W, k<NUM_OUT
  - 0x10+k: DEB[k] debounced input, RO, k<NUM_IN
  - 0x20+k: FLAG[k] change flags, R/W1C, k<NUM_IN
  - 0x30+k: MASK[k] irq enables, R/W, k<NUM_IN
- Valid = hit and offset mapped.
- Reads:
  - o_busNOE = ~valid | i_ioNOE.
  - o_bus is a combinational mux of the addressed register; 0 when not valid.
  - Unmapped offsets inside the window are not driven (NOE high).
- Writes:
  - Occur at the rising edge when valid && ~i_ioNWE; writes to DEB are ignored.
  - OUT and MASK load i_bus.
  - FLAG[k] bit j is cleared if i_bus[j]=1.
- Synchroniser: per bit, two flops (s1, s2); pin change appears in s2 two edges later.
- Debouncer (per port, all 8 bits together):
  - Keeps s2_q (previous s2) and a 16-bit counter cnt.
  - Edge where s2 != s2_q: cnt <= 1.
  - Else if cnt < DEBOUNCE_CYCLES: cnt <= cnt+1.
  - Edge where cnt == DEBOUNCE_CYCLES and s2 == s2_q: DEB <= s2_q.
  - Any new change restarts the count. Stable pin-to-DEB latency is exactly DEBOUNCE_CYCLES+3 edges.
- Change flags:
  - Each edge, FLAG[k] |= DEB_next[k] ^ DEB[k].
  - Simultaneous hardware set and W1C on the same bit: set wins.
- o_irq is registered: o_irq <= OR over k of (FLAG[k] & MASK[k]).
  - Asserts one edge after the flag/mask condition holds and deasserts one edge after it clears.
- After reset DEB=0, so pins that are already high produce a 0->1 change and set flags. Software clears FLAG after initialisation. This is intended behaviour.
- Unused high bits of the address nibble (k >= NUM_OUT/NUM_IN) read undriven, and writes to them are dropped.

Decomposition:
- Shared package io_pkg: window offsets OFF_OUT=6'h00, OFF_IN=6'h10, OFF_FLAG=6'h20, OFF_MASK=6'h30; IO_WIDTH=8; debounce counter width localparam (16).
- Sub-module io_debounce(i_clk, i_reset, i_pins[7:0], o_deb[7:0], o_change[7:0]) containing the synchroniser, counter and change detect.
- io_bank instantiates NUM_IN copies via generate and holds the decode, registers and irq.

Test Plan:
- Reset / output write: write 8'hA5 to BASE+0x01 (NUM_OUT=2) -> o_output[15:8]=A5 next edge, o_output[7:0]=00; read BASE+0x01 gives A5 with o_busNOE=0; assert i_reset -> o_output=0 next edge.
- Debounce latency: DEBOUNCE_CYCLES=4, i_switches[7:0] 00->3C at edge 0 and held -> DEB[0] reads 3C from edge 7, still 00 at edge 6.
- Glitch rejection: i_switches[0] pulses high for 3 clocks with DEBOUNCE_CYCLES=4 -> DEB[0] and FLAG[0] stay 0.
- Flags and irq: MASK[1]=8'h01, port 1 bit0 goes 0->1 -> FLAG[1]=01 and o_irq=1 one edge later; write 8'h01 to BASE+0x21 -> FLAG[1]=00 and o_irq=0 one edge later.
- Set-wins collision: W1C of FLAG[0] bit2 on the same edge that DEB[0] bit2 toggles -> FLAG[0] bit2 remains 1.
- Decode: read at BASE+0x05 with NUM_OUT=2, at BASE+0x40, and with i_ioSelect=0 -> o_busNOE=1 in all cases; writes at these addresses change no register.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the io_bank peripheral: register window offsets,
// data width and debounce counter width.
package io_pkg;
    localparam int IO_WIDTH = 8;
    localparam int CNT_W    = 16;

    localparam logic [5:0] OFF_OUT  = 6'h00;
    localparam logic [5:0] OFF_IN   = 6'h10;
    localparam logic [5:0] OFF_FLAG = 6'h20;
    localparam logic [5:0] OFF_MASK = 6'h30;
endpackage

// File: rtl/io_debounce.sv
// One 8-bit input port: 2-flop synchroniser, shared stability counter and
// debounced value; o_change flags bits that the debounced value flips this edge.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [IO_WIDTH-1:0] i_pins,
    output logic [IO_WIDTH-1:0] o_deb,
    output logic [IO_WIDTH-1:0] o_change
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [IO_WIDTH-1:0] s1_q, s2_q, prev_q, deb_q, deb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        // Any bit moving restarts the window for the whole port.
        if (s2_q != prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_q == LIMIT) && (s2_q == prev_q)) begin
            deb_d = prev_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
        end else begin
            s1_q   <= i_pins;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign o_deb    = deb_q;
    assign o_change = deb_d ^ deb_q;
endmodule

// File: rtl/io_bank.sv
// Memory-mapped I/O bank: NUM_OUT output registers, NUM_IN debounced inputs
// with sticky W1C change flags, per-port masks and a registered interrupt.
module io_bank
    import io_pkg::*;
#(
    parameter int          NUM_OUT         = 2,
    parameter int          NUM_IN          = 2,
    parameter logic [7:0]  BASE_ADDR       = 8'h00,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [IO_WIDTH-1:0]          i_bus,
    output logic [IO_WIDTH-1:0]          o_bus,
    output logic                         o_busNOE,
    input  logic                         i_ioSelect,
    input  logic [7:0]                   i_ioAddress,
    input  logic                         i_ioNOE,
    input  logic                         i_ioNWE,
    output logic [IO_WIDTH*NUM_OUT-1:0]  o_output,
    input  logic [IO_WIDTH*NUM_IN-1:0]   i_switches,
    output logic                         o_irq
);
    logic [IO_WIDTH-1:0] out_q  [NUM_OUT];
    logic [IO_WIDTH-1:0] out_d  [NUM_OUT];
    logic [IO_WIDTH-1:0] flag_q [NUM_IN];
    logic [IO_WIDTH-1:0] flag_d [NUM_IN];
    logic [IO_WIDTH-1:0] mask_q [NUM_IN];
    logic [IO_WIDTH-1:0] mask_d [NUM_IN];
    logic [IO_WIDTH-1:0] deb    [NUM_IN];
    logic [IO_WIDTH-1:0] chg    [NUM_IN];
    logic                irq_q, irq_d;

    logic                hit, valid, wr;
    logic [3:0]          k;
    logic [1:0]          grp;
    logic [IO_WIDTH-1:0] rd;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_pins   (i_switches[IO_WIDTH*g +: IO_WIDTH]),
            .o_deb    (deb[g]),
            .o_change (chg[g])
        );
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign o_output[IO_WIDTH*g +: IO_WIDTH] = out_q[g];
    end

    assign hit = i_ioSelect && (i_ioAddress[7:6] == BASE_ADDR[7:6]);
    assign k   = i_ioAddress[3:0];
    assign grp = i_ioAddress[5:4];

    always_comb begin
        valid = 1'b0;
        if (grp == OFF_OUT[5:4]) begin
            valid = hit && (int'(k) < NUM_OUT);
        end else begin
            valid = hit && (int'(k) < NUM_IN);
        end
    end

    assign wr = valid && !i_ioNWE;

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (grp == OFF_OUT[5:4] && k == 4'(i)) rd = out_q[i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (k == 4'(i)) begin
                if (grp == OFF_IN[5:4])   rd = deb[i];
                if (grp == OFF_FLAG[5:4]) rd = flag_q[i];
                if (grp == OFF_MASK[5:4]) rd = mask_q[i];
            end
        end
    end

    assign o_bus    = valid ? rd : '0;
    assign o_busNOE = ~valid | i_ioNOE;

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_d[i] = out_q[i];
            if (wr && grp == OFF_OUT[5:4] && k == 4'(i)) out_d[i] = i_bus;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            mask_d[i] = mask_q[i];
            flag_d[i] = flag_q[i];
            if (wr && grp == OFF_MASK[5:4] && k == 4'(i)) mask_d[i] = i_bus;
            if (wr && grp == OFF_FLAG[5:4] && k == 4'(i)) flag_d[i] = flag_q[i] & ~i_bus;
            // Hardware set is applied after the clear so a colliding edge is kept.
            flag_d[i] = flag_d[i] | chg[i];
            irq_d     = irq_d | (|(flag_q[i] & mask_q[i]));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                flag_q[i] <= '0;
                mask_q[i] <= '0;
            end
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
            for (int i = 0; i < NUM_IN; i++) begin
                flag_q[i] <= flag_d[i];
                mask_q[i] <= mask_d[i];
            end
            irq_q <= irq_d;
        end
    end

    assign o_irq = irq_q;
endmodule

// File: tb/tb_io_bank.sv
// Directed bench for io_bank: register access table plus debounce, glitch,
// interrupt and set-vs-clear collision sequences.
module tb_io_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_noe;
    logic        sel;
    logic [7:0]  addr;
    logic        noe;
    logic        nwe;
    logic [15:0] outs;
    logic [15:0] sw;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    io_bank #(
        .NUM_OUT(2), .NUM_IN(2), .BASE_ADDR(8'h80), .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_bus(bus_in), .o_bus(bus_out),
        .o_busNOE(bus_noe), .i_ioSelect(sel), .i_ioAddress(addr),
        .i_ioNOE(noe), .i_ioNWE(nwe), .o_output(outs), .i_switches(sw),
        .o_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       sel;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_dat;
        logic       exp_noe;
    } vec_t;

    vec_t tbl [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic s, input logic [7:0] a, input logic [7:0] d);
        sel = s; addr = a; bus_in = d; nwe = 1'b0;
        step();
        sel = 1'b0; nwe = 1'b1; bus_in = 8'h00;
    endtask

    task automatic bus_read(input logic s, input logic [7:0] a,
                            output logic [7:0] d, output logic n);
        sel = s; addr = a; noe = 1'b0;
        #1;
        d = bus_out;
        n = bus_noe;
        sel = 1'b0; noe = 1'b1;
        #1;
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       n;
        bus_read(1'b1, a, d, n);
        check({name, " data"}, {8'h00, d}, {8'h00, exp});
        check({name, " noe"}, {15'h0, n}, 16'h0000);
    endtask

    initial begin
        logic [7:0] d;
        logic       n;

        rst = 1'b1; bus_in = 8'h00; sel = 1'b0; addr = 8'h00;
        noe = 1'b1; nwe = 1'b1; sw = 16'h0000;
        step(); step();
        rst = 1'b0;
        step();

        check("reset o_output", outs, 16'h0000);
        check("reset o_irq", {15'h0, irq}, 16'h0000);
        check_reg("reset DEB0", 8'h90, 8'h00);

        //            sel   wr    addr   wdata  exp   noe
        tbl[0]  = '{1'b1, 1'b1, 8'h81, 8'hA5, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h81, 8'h00, 8'hA5, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'hB0, 8'h5A, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'hB0, 8'h00, 8'h5A, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h85, 8'h00, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 8'h92, 8'h00, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'hC0, 8'h00, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h81, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'h85, 8'hFF, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h90, 8'hFF, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h81, 8'h11, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 8'hC1, 8'h22, 8'h00, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h81, 8'h00, 8'hA5, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'hA0, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].sel, tbl[i].addr, tbl[i].wdata);
            end else begin
                bus_read(tbl[i].sel, tbl[i].addr, d, n);
                check($sformatf("vec%0d data @%h", i, tbl[i].addr),
                      {8'h00, d}, {8'h00, tbl[i].exp_dat});
                check($sformatf("vec%0d noe @%h", i, tbl[i].addr),
                      {15'h0, n}, {15'h0, tbl[i].exp_noe});
            end
        end
        check("table o_output", outs, 16'hA500);

        // Reset wins over a simultaneous write.
        rst = 1'b1; sel = 1'b1; addr = 8'h80; bus_in = 8'hFF; nwe = 1'b0;
        step();
        rst = 1'b0; sel = 1'b0; nwe = 1'b1; bus_in = 8'h00;
        check("reset vs write o_output", outs, 16'h0000);
        check_reg("reset clears MASK0", 8'hB0, 8'h00);

        // Debounce latency: DEB follows at the 7th edge after the change.
        sw[7:0] = 8'h3C;
        repeat (6) step();
        check_reg("DEB0 edge6", 8'h90, 8'h00);
        step();
        check_reg("DEB0 edge7", 8'h90, 8'h3C);
        check_reg("FLAG0 after change", 8'hA0, 8'h3C);
        bus_write(1'b1, 8'hA0, 8'hFF);
        check_reg("FLAG0 cleared", 8'hA0, 8'h00);
        check("irq masked off", {15'h0, irq}, 16'h0000);

        // Three-cycle glitch on bit0 must not pass.
        sw[7:0] = 8'h3D;
        repeat (3) step();
        sw[7:0] = 8'h3C;
        repeat (12) step();
        check_reg("glitch DEB0", 8'h90, 8'h3C);
        check_reg("glitch FLAG0", 8'hA0, 8'h00);

        // Flag raises irq one edge later; W1C drops it one edge later.
        bus_write(1'b1, 8'hB1, 8'h01);
        sw[15:8] = 8'h01;
        repeat (6) step();
        check_reg("FLAG1 edge6", 8'hA1, 8'h00);
        step();
        check_reg("FLAG1 edge7", 8'hA1, 8'h01);
        check("irq edge7", {15'h0, irq}, 16'h0000);
        step();
        check("irq edge8", {15'h0, irq}, 16'h0001);
        bus_write(1'b1, 8'hA1, 8'h01);
        check_reg("FLAG1 W1C", 8'hA1, 8'h00);
        check("irq at clear edge", {15'h0, irq}, 16'h0001);
        step();
        check("irq after clear", {15'h0, irq}, 16'h0000);

        // W1C on the edge where DEB0 bit2 toggles: set wins.
        sw[7:0] = 8'h38;
        repeat (6) step();
        bus_write(1'b1, 8'hA0, 8'h04);
        check_reg("set-wins FLAG0", 8'hA0, 8'h04);
        check_reg("set-wins DEB0", 8'h90, 8'h38);
        check("final o_irq", {15'h0, irq}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
